// File: rtl/instr_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// instr_sequencer_pkg
// Shared definitions for the R-type instruction sequencer and the ALU that
// consumes its alu_control output.
//   - OPCODE_RTYPE : the only opcode the sequencer treats as legal
//   - FUNCT7_*     : the two funct7 values that R-type ALU ops use
//   - alu_op_e     : 4-bit ALU operation select encodings
//   - seq_state_e  : sequencer FSM state encoding
// ----------------------------------------------------------------------------
package instr_sequencer_pkg;

  localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_SLTU = 4'b1011
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/rtype_decoder.sv
// ----------------------------------------------------------------------------
// rtype_decoder
// Purely combinational RV32 R-type decoder.
// Ports:
//   instr       in  32-bit instruction word
//   rs1/rs2/rd  out register-file address fields of the word
//   alu_control out ALU operation select (ALU_AND when illegal)
//   illegal     out 1 when the opcode is not R-type or the funct7/funct3
//                   pair does not name a supported ALU operation
// ----------------------------------------------------------------------------
module rtype_decoder
  import instr_sequencer_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_control,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct7 = instr[31:25];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Map the funct7/funct3 pair to an ALU op; anything unlisted is illegal.
  // An illegal word forces alu_control back to a benign value so the
  // datapath never sees a half-decoded operation.
  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    case ({funct7, funct3})
      {FUNCT7_BASE, 3'b000}: alu_control = ALU_ADD;
      {FUNCT7_ALT,  3'b000}: alu_control = ALU_SUB;
      {FUNCT7_BASE, 3'b001}: alu_control = ALU_SLL;
      {FUNCT7_BASE, 3'b010}: alu_control = ALU_SLT;
      {FUNCT7_BASE, 3'b011}: alu_control = ALU_SLTU;
      {FUNCT7_BASE, 3'b100}: alu_control = ALU_XOR;
      {FUNCT7_BASE, 3'b101}: alu_control = ALU_SRL;
      {FUNCT7_ALT,  3'b101}: alu_control = ALU_SRA;
      {FUNCT7_BASE, 3'b110}: alu_control = ALU_OR;
      {FUNCT7_BASE, 3'b111}: alu_control = ALU_AND;
      default:               illegal     = 1'b1;
    endcase
    if (opcode != OPCODE_RTYPE) begin
      illegal = 1'b1;
    end
    if (illegal) begin
      alu_control = ALU_AND;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control sequencer for RV32 R-type instructions:
// IDLE -> DECODE -> EXEC -> WB -> DONE for legal words, IDLE -> DECODE ->
// DONE for illegal ones. Every output comes straight from a flop.
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   instr_valid, instr  upstream instruction handshake / word
//   instr_ready         high only while idle
//   read_reg_num1/2     rs1 / rs2 register addresses
//   write_reg           rd register address
//   alu_control         ALU operation select
//   regwrite            register-file write enable (WB cycle, rd != 0)
//   zero_flag           ALU zero result, sampled during EXEC
//   done                one-cycle completion pulse
//   err                 illegal-instruction flag, valid with done
//   zero_out            captured zero_flag, valid with done
//   retired             wrapping count of legal instructions completed
// ----------------------------------------------------------------------------
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       read_reg_num1,
  output logic [4:0]       read_reg_num2,
  output logic [4:0]       write_reg,
  output logic [3:0]       alu_control,
  output logic             regwrite,
  input  logic             zero_flag,
  output logic             done,
  output logic             err,
  output logic             zero_out,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       state_q, state_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic [3:0]       alu_q, alu_d;
  logic             illegal_q, illegal_d;
  logic             zero_cap_q, zero_cap_d;
  logic             ready_q, ready_d;
  logic             regwrite_q, regwrite_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             zero_out_q, zero_out_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             handshake;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;
  logic [3:0]       dec_alu;
  logic             dec_illegal;

  // The incoming word is decoded before it is captured, so the registered
  // address/opcode fields are already valid in the DECODE cycle and the raw
  // instruction never needs its own holding register.
  rtype_decoder u_decoder (
    .instr       (instr),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  assign handshake = (state_q == ST_IDLE) && instr_valid;

  // Next-state and next-output logic. Outputs are derived from the state
  // being entered, so each flop shows the value belonging to the new state.
  always_comb begin
    state_d    = state_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    alu_d      = alu_q;
    illegal_d  = illegal_q;
    zero_cap_d = zero_cap_q;
    retired_d  = retired_q;

    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = illegal_q ? ST_DONE : ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (handshake) begin
      rs1_d     = dec_rs1;
      rs2_d     = dec_rs2;
      rd_d      = dec_rd;
      alu_d     = dec_alu;
      illegal_d = dec_illegal;
    end

    if (state_q == ST_EXEC) begin
      zero_cap_d = zero_flag;
    end

    ready_d    = (state_d == ST_IDLE);
    regwrite_d = (state_d == ST_WB) && (rd_q != 5'd0);
    done_d     = (state_d == ST_DONE);
    err_d      = done_d && illegal_q;
    zero_out_d = done_d && !illegal_q && zero_cap_q;

    if (done_d && !illegal_q) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State and output registers; reset aborts any instruction in flight and
  // returns the block to its power-up condition.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      alu_q      <= 4'd0;
      illegal_q  <= 1'b0;
      zero_cap_q <= 1'b0;
      ready_q    <= 1'b1;
      regwrite_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      zero_out_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alu_q      <= alu_d;
      illegal_q  <= illegal_d;
      zero_cap_q <= zero_cap_d;
      ready_q    <= ready_d;
      regwrite_q <= regwrite_d;
      done_q     <= done_d;
      err_q      <= err_d;
      zero_out_q <= zero_out_d;
      retired_q  <= retired_d;
    end
  end

  assign instr_ready   = ready_q;
  assign read_reg_num1 = rs1_q;
  assign read_reg_num2 = rs2_q;
  assign write_reg     = rd_q;
  assign alu_control   = alu_q;
  assign regwrite      = regwrite_q;
  assign done          = done_q;
  assign err           = err_q;
  assign zero_out      = zero_out_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instr_sequencer
// Drives the sequencer with directed and random R-type words and compares
// every cycle against an instruction-level model: latency from the decode
// table, regwrite/done timing, zero-flag capture and the retired count.
// A second instance with a 2-bit counter shares all inputs to cover wrap.
// ----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero_flag = 1'b0;

  logic        instr_ready, regwrite, done, err, zero_out;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu;
  logic [15:0] retired;

  logic        instr_ready2, regwrite2, done2, err2, zero_out2;
  logic [4:0]  rs1_2, rs2_2, rd_2;
  logic [3:0]  alu2;
  logic [1:0]  retired2;

  int          checks = 0;
  int          failures = 0;
  int          exp_count = 0;
  time         hs_time = 0;

  // funct7 | funct3 | alu_control, straight from the decode table
  localparam logic [13:0] DEC_TABLE [10] = '{
    {7'b0000000, 3'b000, 4'b0010},
    {7'b0100000, 3'b000, 4'b0110},
    {7'b0000000, 3'b001, 4'b1000},
    {7'b0000000, 3'b010, 4'b0111},
    {7'b0000000, 3'b011, 4'b1011},
    {7'b0000000, 3'b100, 4'b0100},
    {7'b0000000, 3'b101, 4'b1001},
    {7'b0100000, 3'b101, 4'b1010},
    {7'b0000000, 3'b110, 4'b0001},
    {7'b0000000, 3'b111, 4'b0000}
  };

  instr_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .read_reg_num1(rs1), .read_reg_num2(rs2),
    .write_reg(rd), .alu_control(alu), .regwrite(regwrite),
    .zero_flag(zero_flag), .done(done), .err(err), .zero_out(zero_out),
    .retired(retired)
  );

  instr_sequencer #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready2), .read_reg_num1(rs1_2), .read_reg_num2(rs2_2),
    .write_reg(rd_2), .alu_control(alu2), .regwrite(regwrite2),
    .zero_flag(zero_flag), .done(done2), .err(err2), .zero_out(zero_out2),
    .retired(retired2)
  );

  always #5 clock = ~clock;

  // Table lookup of legality and ALU code for a 32-bit word
  function automatic void ref_decode(input logic [31:0] w, output logic legal,
                                     output logic [3:0] op);
    logic [13:0] ent;
    legal = 1'b0;
    op    = 4'b0000;
    if (w[6:0] == 7'b0110011) begin
      for (int i = 0; i < 10; i++) begin
        ent = DEC_TABLE[i];
        if (ent[13:4] == {w[31:25], w[14:12]}) begin
          legal = 1'b1;
          op    = ent[3:0];
        end
      end
    end
  endfunction

  function automatic logic [31:0] rand_legal(input bit allow_rd0);
    logic [13:0] ent;
    logic [4:0]  rdv;
    ent = DEC_TABLE[$urandom_range(0, 9)];
    rdv = 5'($urandom);
    if (allow_rd0 && ($urandom_range(0, 3) == 0)) rdv = 5'd0;
    return {ent[13:7], 5'($urandom), 5'($urandom), ent[6:4], rdv, 7'b0110011};
  endfunction

  // Issue one word and follow it to completion. zf_val < 0 randomizes the
  // zero flag every cycle; hold keeps instr_valid/instr steady throughout.
  task automatic run_instr(input logic [31:0] word, input int zf_val,
                           input bit hold, input string tag);
    logic        legal;
    logic [3:0]  op;
    int          lat;
    int          n;
    logic        zf_exec;
    logic [4:0]  obs_ctl, obs_ctl2, exp_ctl;
    logic [18:0] obs_f, obs_f2, exp_f;
    ref_decode(word, legal, op);
    lat = legal ? 4 : 2;
    zf_exec = 1'b0;
    n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s ready_timeout got=%b want=1", tag, instr_ready);
      return;
    end
    instr_valid = 1'b1;
    instr       = word;
    zero_flag   = 1'($urandom);
    @(posedge clock);
    hs_time = $time;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clock);
      obs_ctl  = {instr_ready, regwrite, done, err, zero_out};
      obs_ctl2 = {instr_ready2, regwrite2, done2, err2, zero_out2};
      exp_ctl  = {(k > lat), (legal && (k == 3) && (word[11:7] != 5'd0)),
                  (k == lat), (!legal && (k == lat)),
                  (legal && (k == lat) && zf_exec)};
      checks++;
      if (obs_ctl !== exp_ctl || obs_ctl2 !== exp_ctl) begin
        failures++;
        $display("[TB] FAIL %s ctl cycle=%0d rdy/rw/done/err/zo got=%b/%b want=%b",
                 tag, k, obs_ctl, obs_ctl2, exp_ctl);
      end
      if (legal && k <= 3) begin
        obs_f  = {rs1, rs2, rd, alu};
        obs_f2 = {rs1_2, rs2_2, rd_2, alu2};
        exp_f  = {word[19:15], word[24:20], word[11:7], op};
        checks++;
        if (obs_f !== exp_f || obs_f2 !== exp_f) begin
          failures++;
          $display("[TB] FAIL %s fields cycle=%0d rs1/rs2/rd/alu got=%h/%h want=%h",
                   tag, k, obs_f, obs_f2, exp_f);
        end
      end
      if (k == lat) begin
        if (legal) exp_count++;
        checks++;
        if (retired !== exp_count[15:0] || retired2 !== exp_count[1:0]) begin
          failures++;
          $display("[TB] FAIL %s retired got=%0d/%0d want=%0d/%0d", tag, retired,
                   retired2, exp_count[15:0], exp_count[1:0]);
        end
      end
      if (k <= lat) begin
        if (!hold) begin
          instr_valid = 1'($urandom);
          instr       = $urandom;
        end
        zero_flag = (zf_val < 0) ? 1'($urandom) : 1'(zf_val);
        if (k == 2) zf_exec = zero_flag;
      end
    end
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({instr_ready, regwrite, done, err, zero_out} !== 5'b10000 ||
        {instr_ready2, regwrite2, done2, err2, zero_out2} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_ctl got=%b/%b want=10000",
               {instr_ready, regwrite, done, err, zero_out},
               {instr_ready2, regwrite2, done2, err2, zero_out2});
    end
    checks++;
    if ({rs1, rs2, rd, alu} !== 19'd0 || {rs1_2, rs2_2, rd_2, alu2} !== 19'd0) begin
      failures++;
      $display("[TB] FAIL reset_fields got=%h/%h want=0", {rs1, rs2, rd, alu},
               {rs1_2, rs2_2, rd_2, alu2});
    end
    checks++;
    if (retired !== 16'd0 || retired2 !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_retired got=%0d/%0d want=0", retired, retired2);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_add;
    run_instr(32'h002081B3, -1, 1'b0, "add");
  endtask

  task automatic test_sub_zero;
    run_instr(32'h404202B3, 1, 1'b0, "sub_zero");
    run_instr(32'h404202B3, 0, 1'b0, "sub_nonzero");
  endtask

  task automatic test_illegal;
    run_instr(32'h00108093, -1, 1'b0, "illegal_opcode");
    run_instr(32'h4000F0B3, -1, 1'b0, "illegal_funct");
  endtask

  task automatic test_rd_zero;
    run_instr(32'h00208033, -1, 1'b0, "rd_zero");
  endtask

  task automatic test_back_to_back;
    time t0;
    for (int i = 0; i < 3; i++) begin
      t0 = hs_time;
      run_instr(rand_legal(1'b0), -1, 1'b1, "back_to_back");
      if (i > 0) begin
        checks++;
        if (hs_time - t0 != 50) begin
          failures++;
          $display("[TB] FAIL back_to_back_spacing got=%0t want=50", hs_time - t0);
        end
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    instr_valid = 1'b1;
    instr       = 32'h002081B3;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (regwrite !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_wb regwrite got=%b want=1", regwrite);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({instr_ready, regwrite, done, err, zero_out} !== 5'b10000 ||
        retired !== 16'd0 || retired2 !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_abort ctl got=%b retired=%0d want=10000 retired=0",
               {instr_ready, regwrite, done, err, zero_out}, retired);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || regwrite !== 1'b0 || instr_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_mid_hold done/rw/rdy got=%b%b%b want=001",
                 done, regwrite, instr_ready);
      end
    end
    reset = 1'b1;
    exp_count = 0;
    run_instr(32'h002081B3, -1, 1'b0, "after_reset");
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) begin
      run_instr(rand_legal(1'b1), -1, 1'b0, "wrap");
    end
  endtask

  task automatic test_random;
    logic [31:0] w;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 0) w = rand_legal(1'b1);
      else if ($urandom_range(0, 1) == 0) w = {$urandom} & 32'hFFFF_FF80 | 32'h13;
      else w = $urandom;
      run_instr(w, -1, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_illegal();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
